motor_speed_ctrl: RTL and testbench

Speed-level controller and PWM sequencer for the motor front panel. It synchronises the `swt_start_stop`, `swt_increase` and `swt_decrease` switches and maintains a 0–9 speed level. It sequences start and stop, with an optional soft ramp, and generates the glitch-free `motor_pwm` waveform, the `motor_running` flag and the 7-segment level display. It sits between the board switches and the motor driver pin.

---
 rtl/motor_speed_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_motor_speed_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_speed_ctrl.sv
// Motor speed-level controller: switch synchronisers, start/stop sequencer, PWM and 7-segment display.
// Optional soft start/stop ramp enabled by defining SOFT_START_EN.
module motor_speed_ctrl #(
    parameter int unsigned PWM_STEP    = 10,
    parameter int unsigned START_LEVEL = 5,
    parameter int unsigned RAMP_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       swt_start_stop,
    input  logic       swt_increase,
    input  logic       swt_decrease,
    output logic       motor_pwm,
    output logic       motor_running,
    output logic [3:0] level,
    output logic [6:0] display
);

    localparam int unsigned PERIOD    = 10 * PWM_STEP;
    localparam int unsigned CW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [3:0]  LVL_START = 4'(START_LEVEL);
    localparam logic [3:0]  LVL_MAX   = 4'd9;

    localparam logic [1:0] ST_STANDBY  = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd2;
`ifdef SOFT_START_EN
    localparam logic [1:0] ST_STARTING = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd3;
    localparam int unsigned RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
`endif

    if (START_LEVEL < 1 || START_LEVEL > 9) begin : g_bad_start_level
        $error("START_LEVEL must be in 1..9");
    end
    if (PWM_STEP < 1 || RAMP_CYCLES < 1) begin : g_bad_step
        $error("PWM_STEP and RAMP_CYCLES must be at least 1");
    end

    logic [2:0] sync1, sync2;
    logic       inc_prev, dec_prev;
    logic       run_req, inc_evt, dec_evt;
    logic [1:0] state, state_next;
    logic [3:0] level_next;
    logic [CW-1:0] pwm_cnt;
    logic [CW-1:0] duty_thr;
    logic [3:0]    duty_q;
    logic          pwm_wrap;
`ifdef SOFT_START_EN
    logic [RW-1:0] ramp_cnt, ramp_cnt_next;
    logic          ramp_tick;
    assign ramp_tick = (ramp_cnt == RW'(RAMP_CYCLES - 1));
`endif

    // Bit order {start_stop, increase, decrease}; events are rising edges of the synchronised value
    assign run_req = sync2[2];
    assign inc_evt = sync2[1] & ~inc_prev;
    assign dec_evt = sync2[0] & ~dec_prev;

    always_comb begin
        state_next = state;
        level_next = level;
`ifdef SOFT_START_EN
        ramp_cnt_next = ramp_cnt + RW'(1);
`endif
        case (state)
            ST_STANDBY: begin
                level_next = 4'd0;
                if (run_req) begin
`ifdef SOFT_START_EN
                    state_next = ST_STARTING;
`else
                    state_next = ST_RUN;
                    level_next = LVL_START;
`endif
                end
            end
            ST_RUN: begin
                if (!run_req) begin
`ifdef SOFT_START_EN
                    state_next = ST_STOPPING;
`else
                    state_next = ST_STANDBY;
                    level_next = 4'd0;
`endif
                end else if (inc_evt && !dec_evt) begin
                    if (level < LVL_MAX) level_next = level + 4'd1;
                end else if (dec_evt && !inc_evt) begin
                    if (level != 4'd0) level_next = level - 4'd1;
                end
            end
`ifdef SOFT_START_EN
            ST_STARTING: begin
                if (!run_req) begin
                    state_next = ST_STOPPING;
                end else if (level >= LVL_START) begin
                    state_next = ST_RUN;
                end else if (ramp_tick) begin
                    level_next = level + 4'd1;
                    if (level + 4'd1 == LVL_START) state_next = ST_RUN;
                end
            end
            ST_STOPPING: begin
                if (run_req) begin
                    state_next = ST_STARTING;
                end else if (level == 4'd0) begin
                    state_next = ST_STANDBY;
                end else if (ramp_tick) begin
                    level_next = level - 4'd1;
                    if (level == 4'd1) state_next = ST_STANDBY;
                end
            end
`endif
            default: begin
                state_next = ST_STANDBY;
                level_next = 4'd0;
            end
        endcase
`ifdef SOFT_START_EN
        if (ramp_tick || state_next != state) ramp_cnt_next = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1         <= '0;
            sync2         <= '0;
            inc_prev      <= 1'b0;
            dec_prev      <= 1'b0;
            state         <= ST_STANDBY;
            level         <= 4'd0;
            motor_running <= 1'b0;
`ifdef SOFT_START_EN
            ramp_cnt      <= '0;
`endif
        end else begin
            sync1         <= {swt_start_stop, swt_increase, swt_decrease};
            sync2         <= sync1;
            inc_prev      <= sync2[1];
            dec_prev      <= sync2[0];
            state         <= state_next;
            level         <= level_next;
            motor_running <= (state_next != ST_STANDBY);
`ifdef SOFT_START_EN
            ramp_cnt      <= ramp_cnt_next;
`endif
        end
    end

    // Duty is only reloaded at the period wrap so a period is never cut short or stretched
    assign pwm_wrap = (pwm_cnt == CW'(PERIOD - 1));
    assign duty_thr = CW'(duty_q * PWM_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            duty_q    <= 4'd0;
            motor_pwm <= 1'b0;
        end else begin
            motor_pwm <= (pwm_cnt < duty_thr);
            if (pwm_wrap) begin
                pwm_cnt <= '0;
                duty_q  <= level;
            end else begin
                pwm_cnt <= pwm_cnt + CW'(1);
            end
        end
    end

    // Active-low segments, bit order gfedcba
    always_comb begin
        case (level)
            4'd0:    display = 7'b1000000;
            4'd1:    display = 7'b1111001;
            4'd2:    display = 7'b0100100;
            4'd3:    display = 7'b0110000;
            4'd4:    display = 7'b0011001;
            4'd5:    display = 7'b0010010;
            4'd6:    display = 7'b0000010;
            4'd7:    display = 7'b1111000;
            4'd8:    display = 7'b0000000;
            4'd9:    display = 7'b0010000;
            default: display = 7'b0111111;
        endcase
    end

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Self-checking bench for motor_speed_ctrl: vector table plus hand-written multi-cycle sequences.
// Covers both builds; the soft ramp sequences are selected by SOFT_START_EN.
module tb_motor_speed_ctrl;

    localparam int unsigned PWM_STEP    = 2;
    localparam int unsigned START_LEVEL = 5;
    localparam int unsigned RAMP_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       swt_start_stop;
    logic       swt_increase;
    logic       swt_decrease;
    logic       motor_pwm;
    logic       motor_running;
    logic [3:0] level;
    logic [6:0] display;

    motor_speed_ctrl #(
        .PWM_STEP   (PWM_STEP),
        .START_LEVEL(START_LEVEL),
        .RAMP_CYCLES(RAMP_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .swt_start_stop(swt_start_stop),
        .swt_increase  (swt_increase),
        .swt_decrease  (swt_decrease),
        .motor_pwm     (motor_pwm),
        .motor_running (motor_running),
        .level         (level),
        .display       (display)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       inc;
        logic       dec;
        logic [3:0] lvl;
        logic       zero_chk;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] lvl;
        logic       run;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[20];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp_v);
        end
    endtask

    // n rising edges, then settle on the following falling edge
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input string nm, input logic [3:0] lvl, input logic run);
        exp_t e;
        e.name = nm;
        e.lvl  = lvl;
        e.run  = run;
        sbq.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        if (sbq.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            check({e.name, "_level"}, int'(level), int'(e.lvl));
            check({e.name, "_display"}, int'(display), int'(seg(e.lvl)));
            check({e.name, "_running"}, int'(motor_running), int'(e.run));
        end
    endtask

    task automatic apply(input logic i, input logic d, input logic [3:0] lvl, input string nm);
        push(nm, lvl, 1'b1);
        swt_increase = i;
        swt_decrease = d;
        edges(3);
        score();
        swt_increase = 1'b0;
        swt_decrease = 1'b0;
        edges(2);
    endtask

    task automatic pwm_high(input int n, output int hi);
        hi = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (motor_pwm) hi++;
        end
    endtask

    initial begin
        int   hi, ha, hb;
        logic found, prev_p;

        tbl = '{
            '{1'b1, 1'b0, 4'd6, 1'b0}, '{1'b1, 1'b0, 4'd7, 1'b0}, '{1'b1, 1'b0, 4'd8, 1'b0},
            '{1'b1, 1'b0, 4'd9, 1'b0}, '{1'b1, 1'b0, 4'd9, 1'b0},
            '{1'b0, 1'b1, 4'd8, 1'b0}, '{1'b0, 1'b1, 4'd7, 1'b0}, '{1'b0, 1'b1, 4'd6, 1'b0},
            '{1'b0, 1'b1, 4'd5, 1'b0}, '{1'b0, 1'b1, 4'd4, 1'b0}, '{1'b0, 1'b1, 4'd3, 1'b0},
            '{1'b0, 1'b1, 4'd2, 1'b0}, '{1'b0, 1'b1, 4'd1, 1'b0}, '{1'b0, 1'b1, 4'd0, 1'b0},
            '{1'b0, 1'b1, 4'd0, 1'b1},
            '{1'b1, 1'b0, 4'd1, 1'b0}, '{1'b1, 1'b0, 4'd2, 1'b0}, '{1'b1, 1'b0, 4'd3, 1'b0},
            '{1'b1, 1'b0, 4'd4, 1'b0}, '{1'b1, 1'b1, 4'd4, 1'b0}
        };

        rst            = 1'b1;
        swt_start_stop = 1'b0;
        swt_increase   = 1'b0;
        swt_decrease   = 1'b0;
        edges(3);
        check("reset_pwm", int'(motor_pwm), 0);
        check("reset_running", int'(motor_running), 0);
        check("reset_level", int'(level), 0);
        check("reset_display", int'(display), 7'b1000000);
        rst = 1'b0;
        edges(2);

        // Start: nothing visible at E1, state change at E2
        swt_start_stop = 1'b1;
        edges(2);
        check("start_e1_level", int'(level), 0);
        check("start_e1_running", int'(motor_running), 0);
`ifdef SOFT_START_EN
        edges(1);
        check("ramp_entry_running", int'(motor_running), 1);
        check("ramp_entry_level", int'(level), 0);
        edges(7);
        check("ramp_hold_level", int'(level), 0);
        edges(1);
        check("ramp_step_1", int'(level), 1);
        for (int k = 2; k <= 5; k++) begin
            edges(8);
            check($sformatf("ramp_step_%0d", k), int'(level), k);
        end
        push("ramp_done", 4'd5, 1'b1);
        score();
`else
        push("start_jump", 4'(START_LEVEL), 1'b1);
        edges(1);
        score();
`endif

        edges(45);
        pwm_high(20, hi);
        check("pwm_duty_5", hi, 10);

        // Saturation, zero level and simultaneous press from the table
        foreach (tbl[i]) begin
            apply(tbl[i].inc, tbl[i].dec, tbl[i].lvl, $sformatf("vec%0d", i));
            if (tbl[i].zero_chk) begin
                edges(42);
                pwm_high(40, hi);
                check("pwm_level0", hi, 0);
                check("level0_running", int'(motor_running), 1);
            end
        end

        // Glitch-free PWM: raise 2 -> 8 just after a period starts
        apply(1'b0, 1'b1, 4'd3, "dec_to_3");
        apply(1'b0, 1'b1, 4'd2, "dec_to_2");
        edges(45);
        found  = 1'b0;
        prev_p = motor_pwm;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!prev_p && motor_pwm) begin
                found = 1'b1;
                break;
            end
            prev_p = motor_pwm;
        end
        check("pwm_period_start_found", int'(found), 1);
        if (found) begin
            push("rapid_inc", 4'd8, 1'b1);
            ha = 0;
            hb = 0;
            for (int s = 0; s < 40; s++) begin
                if (motor_pwm) begin
                    if (s < 20) ha++;
                    else hb++;
                end
                swt_increase = (s < 12) && (s % 2 == 0);
                @(negedge clk);
            end
            swt_increase = 1'b0;
            check("pwm_current_period", ha, 4);
            check("pwm_next_period", hb, 16);
            score();
            edges(2);
        end

`ifdef SOFT_START_EN
        // Stop at 9, ramp down to 6, restart there
        apply(1'b1, 1'b0, 4'd9, "inc_to_9");
        swt_start_stop = 1'b0;
        edges(3);
        check("stopping_running", int'(motor_running), 1);
        check("stopping_entry_level", int'(level), 9);
        edges(24);
        check("stopping_level_6", int'(level), 6);
        swt_start_stop = 1'b1;
        edges(3);
        check("restart_level", int'(level), 6);
        check("restart_running", int'(motor_running), 1);
        edges(1);
        apply(1'b1, 1'b0, 4'd7, "run_after_restart");
`else
        apply(1'b0, 1'b1, 4'd7, "dec_to_7");
        push("stop", 4'd0, 1'b0);
        swt_start_stop = 1'b0;
        edges(2);
        check("stop_e1_level", int'(level), 7);
        check("stop_e1_running", int'(motor_running), 1);
        edges(1);
        score();
        push("restart", 4'(START_LEVEL), 1'b1);
        swt_start_stop = 1'b1;
        edges(3);
        score();
        apply(1'b1, 1'b0, 4'd6, "inc_to_6");
        apply(1'b1, 1'b0, 4'd7, "inc_to_7");
`endif

        // Asynchronous reset while running at 7 with PWM high
        edges(45);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (motor_pwm) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("pwm_high_before_reset", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_pwm", int'(motor_pwm), 0);
        check("async_reset_running", int'(motor_running), 0);
        check("async_reset_level", int'(level), 0);
        check("async_reset_display", int'(display), 7'b1000000);
        @(negedge clk);
        rst = 1'b0;
        swt_start_stop = 1'b0;
        edges(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
